// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide engine bundle: op request, HI/LO access, status and HI/LO view.
interface muldiv_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              hilo_read;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wdata;
    logic              flush;
    logic              stall;
    logic              busy;
    logic              done;
    logic              div0;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hilo_read, hi_we, lo_we, wdata, flush,
        input  stall, busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hilo_read, hi_we, lo_we, wdata, flush,
        output stall, busy, done, div0, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine and HI/LO owner with hazard stall.
// Define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned      PROD_W    = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Datapath: acc holds the product, or {remainder, dividend/quotient} for divides.
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] mcand;
    logic [DATA_W-1:0] opb;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic              neg_res;
    logic              neg_rem;

    logic              accept;
    logic              div_zero;
    logic              hi_wr;
    logic              lo_wr;
    logic              commit;
    logic              last_iter;
    logic              op_is_div;
    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [DATA_W:0]   trial;
    logic [PROD_W-1:0] prod_fix;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    assign bus.stall = bus.busy & (bus.start | bus.hilo_read | bus.hi_we | bus.lo_we);

    assign op_is_div = bus.op[1];
    assign op_signed = ~bus.op[0];
    assign a_neg     = op_signed & bus.src_a[DATA_W-1];
    assign b_neg     = op_signed & bus.src_b[DATA_W-1];
    assign abs_a     = a_neg ? -bus.src_a : bus.src_a;
    assign abs_b     = b_neg ? -bus.src_b : bus.src_b;

    // Restoring step: shift in the next dividend bit and try to subtract the divisor.
    assign trial     = acc[PROD_W-1:DATA_W-1] - {1'b0, opb};

    assign prod_fix  = neg_res ? -acc : acc;
    assign quot_fix  = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem_fix   = neg_rem ? -acc[PROD_W-1:DATA_W] : acc[PROD_W-1:DATA_W];

`ifdef MULDIV_EARLY_OUT_EN
    assign last_iter = (cnt == LAST_ITER) | (~is_div & (opb[DATA_W-1:1] == '0));
`else
    assign last_iter = (cnt == LAST_ITER);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        div_zero  = 1'b0;
        hi_wr     = 1'b0;
        lo_wr     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.flush) begin
                    if (bus.start) begin
                        if (op_is_div && (bus.src_b == '0)) begin
                            div_zero = 1'b1;
                        end else begin
                            accept    = 1'b1;
                            state_nxt = CALC;
                        end
                    end else begin
                        hi_wr = bus.hi_we;
                        lo_wr = bus.lo_we;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
                commit    = ~bus.flush;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            opb      <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.div0 <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.busy <= (state_nxt != IDLE);
            bus.done <= commit | div_zero;
            bus.div0 <= div_zero;

            if (accept) begin
                is_div  <= op_is_div;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                cnt     <= '0;
                opb     <= abs_b;
                mcand   <= PROD_W'(abs_a);
                acc     <= op_is_div ? PROD_W'(abs_a) : '0;
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (is_div) begin
                    if (!trial[DATA_W]) begin
                        acc <= {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                    end else begin
                        acc <= {acc[PROD_W-2:0], 1'b0};
                    end
                end else begin
                    if (opb[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= {mcand[PROD_W-2:0], 1'b0};
                    opb   <= {1'b0, opb[DATA_W-1:1]};
                end
            end

            // Result commit at the end of FIX has priority; MTHI/MTLO only land while idle.
            if (commit) begin
                if (is_div) begin
                    bus.lo <= quot_fix;
                    bus.hi <= rem_fix;
                end else begin
                    bus.hi <= prod_fix[PROD_W-1:DATA_W];
                    bus.lo <= prod_fix[DATA_W-1:0];
                end
            end else begin
                if (hi_wr) begin
                    bus.hi <= bus.wdata;
                end
                if (lo_wr) begin
                    bus.lo <= bus.wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: per-cycle reference model plus directed literal checks.
module tb_muldiv_sequencer;
    localparam int unsigned DATA_W = 32;
    localparam int          LAT    = DATA_W + 2;
    localparam int          BUSY_N = DATA_W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    muldiv_sequencer_if #(.DATA_W(DATA_W)) bus ();

    muldiv_sequencer #(.DATA_W(DATA_W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result as {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        sa = op[0] ? longint'({32'h0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'h0, b}) : longint'($signed(b));
        if (!op[1]) return 64'(sa * sb);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // Reference model: busy countdown, pending result, HI/LO and pulses.
    int          m_left = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_done = 1'b0;
    logic        m_div0 = 1'b0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_div0 = 1'b0; m_pend = '0;
        end else begin
            m_done = 1'b0;
            m_div0 = 1'b0;
            if (m_left != 0) begin
                if (bus.flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = m_pend[63:32];
                        m_lo = m_pend[31:0];
                        m_done = 1'b1;
                    end
                end
            end else if (!bus.flush) begin
                if (bus.start) begin
                    if (bus.op[1] && bus.src_b == '0) begin
                        m_done = 1'b1;
                        m_div0 = 1'b1;
                    end else begin
                        m_pend = ref_result(bus.op, bus.src_a, bus.src_b);
                        m_left = BUSY_N;
                    end
                end else begin
                    if (bus.hi_we) m_hi = bus.wdata;
                    if (bus.lo_we) m_lo = bus.wdata;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_left != 0);
        check("stall", bus.stall, m_busy & (bus.start | bus.hilo_read | bus.hi_we | bus.lo_we));
        check("busy", bus.busy, m_busy);
        check("done", bus.done, m_done);
        check("div0", bus.div0, m_div0);
        check("hi", bus.hi, m_hi);
        check("lo", bus.lo, m_lo);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.hilo_read = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.flush = 1'b0;
    endtask

    // Issue one op from idle, then measure done latency and busy length against literals.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input int exp_busy,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        int nbusy;
        bit seen;
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        cyc(1);
        bus.start = 1'b0;
        lat = 0; nbusy = 0; seen = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                seen = 1'b1;
                lat = i;
            end
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_busy_cycles"}, 64'(nbusy), 64'(exp_busy));
        check({nm, "_hi"}, bus.hi, ehi);
        check({nm, "_lo"}, bus.lo, elo);
        cyc(1);
    endtask

    initial begin
        logic [63:0] r;
        bit          saw_done;
        clear_inputs();
        #2 rst_n = 1'b0;
        cyc(2);
        check("reset_hi", bus.hi, 32'h0);
        check("reset_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        cyc(1);

        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        cyc(1);
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h5678;
        cyc(1);
        bus.lo_we = 1'b0;
        check("mthi", bus.hi, 32'h0000_1234);
        check("mtlo", bus.lo, 32'h0000_5678);

        run_op("mult_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, BUSY_N, 32'h0, 32'h1);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, BUSY_N, 32'hFFFF_FFFE, 32'h1);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h2, LAT, BUSY_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, LAT, BUSY_N, 32'd2, 32'd14);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, LAT, BUSY_N, 32'h0, 32'h8000_0000);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 1, 0, 32'h0, 32'h8000_0000);

        // MFHI behind a busy multiply: held until the result lands.
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9ABC_DEF0;
        cyc(1);
        bus.start = 1'b0;
        cyc(2);
        bus.hilo_read = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.stall) begin
                saw_done = bus.done;
                break;
            end
        end
        check("mfhi_release_on_done", saw_done, 1'b1);
        r = ref_result(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        check("mfhi_value", bus.hi, r[63:32]);
        cyc(1);
        bus.hilo_read = 1'b0;

        // Second multiply presented while the first is busy.
        bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd7; bus.src_b = 32'd9;
        cyc(1);
        bus.src_a = 32'd3; bus.src_b = 32'hFFFF_FFFB;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
        end
        check("first_mult_lo", bus.lo, 32'd63);
        run_op("mult_after_stall", 2'b00, 32'd3, 32'hFFFF_FFFB, LAT, BUSY_N, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // Flush at CALC cycle 10: no commit, HI/LO retained.
        bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd7; bus.src_b = 32'd9;
        cyc(1);
        bus.start = 1'b0;
        cyc(9);
        bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 1'b0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check("flush_no_done", saw_done, 1'b0);
        check("flush_hi", bus.hi, 32'hFFFF_FFFF);
        check("flush_lo", bus.lo, 32'hFFFF_FFF1);

        // Flush in idle drops an MTHI.
        cyc(1);
        bus.flush = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        cyc(1);
        bus.flush = 1'b0; bus.hi_we = 1'b0;
        check("flush_idle_hi", bus.hi, 32'hFFFF_FFFF);

        // Start together with MTLO: the start wins.
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd9; bus.src_b = 32'd4; bus.lo_we = 1'b1;
        bus.wdata = 32'h0BAD_0BAD;
        cyc(1);
        bus.start = 1'b0; bus.lo_we = 1'b0;
        check("start_wins_lo", bus.lo, 32'hFFFF_FFF1);
        cyc(LAT);
        check("start_wins_result", {bus.hi, bus.lo}, {32'd1, 32'd2});

        // Reset in the middle of CALC.
        bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd100; bus.src_b = 32'd7;
        cyc(1);
        bus.start = 1'b0;
        cyc(4);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {bus.hi, bus.lo, bus.busy, bus.done, bus.div0}, '0);
        cyc(1);
        rst_n = 1'b1;
        cyc(LAT);
        check("rst_mid_no_commit", {bus.hi, bus.lo}, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
